// File: rtl/i2c_master_arbiter_if.sv
// rtl/i2c_master_arbiter_if.sv - requester-side and i2c_master-side signal bundle for the arbiter
interface i2c_master_arbiter_if #(
    parameter int PORTS = 2
);
    logic [PORTS*7-1:0] s_cmd_address;
    logic [PORTS-1:0]   s_cmd_start;
    logic [PORTS-1:0]   s_cmd_read;
    logic [PORTS-1:0]   s_cmd_write;
    logic [PORTS-1:0]   s_cmd_write_multiple;
    logic [PORTS-1:0]   s_cmd_stop;
    logic [PORTS-1:0]   s_cmd_valid;
    logic [PORTS-1:0]   s_cmd_ready;
    logic [PORTS*8-1:0] s_data_in_tdata;
    logic [PORTS-1:0]   s_data_in_tvalid;
    logic [PORTS-1:0]   s_data_in_tlast;
    logic [PORTS-1:0]   s_data_in_tready;
    logic [7:0]         s_data_out_tdata;
    logic [PORTS-1:0]   s_data_out_tvalid;
    logic [PORTS-1:0]   s_data_out_tlast;
    logic [PORTS-1:0]   s_data_out_tready;
    logic [6:0]         m_cmd_address;
    logic               m_cmd_start;
    logic               m_cmd_read;
    logic               m_cmd_write;
    logic               m_cmd_write_multiple;
    logic               m_cmd_stop;
    logic               m_cmd_valid;
    logic               m_cmd_ready;
    logic [7:0]         m_data_in_tdata;
    logic               m_data_in_tvalid;
    logic               m_data_in_tlast;
    logic               m_data_in_tready;
    logic [7:0]         m_data_out_tdata;
    logic               m_data_out_tvalid;
    logic               m_data_out_tlast;
    logic               m_data_out_tready;

    // Arbiter view
    modport slave (
        input  s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
               s_cmd_stop, s_cmd_valid, s_data_in_tdata, s_data_in_tvalid, s_data_in_tlast,
               s_data_out_tready, m_cmd_ready, m_data_in_tready, m_data_out_tdata,
               m_data_out_tvalid, m_data_out_tlast,
        output s_cmd_ready, s_data_in_tready, s_data_out_tdata, s_data_out_tvalid,
               s_data_out_tlast, m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write,
               m_cmd_write_multiple, m_cmd_stop, m_cmd_valid, m_data_in_tdata,
               m_data_in_tvalid, m_data_in_tlast, m_data_out_tready
    );

    // Requesters plus i2c_master view
    modport master (
        output s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
               s_cmd_stop, s_cmd_valid, s_data_in_tdata, s_data_in_tvalid, s_data_in_tlast,
               s_data_out_tready, m_cmd_ready, m_data_in_tready, m_data_out_tdata,
               m_data_out_tvalid, m_data_out_tlast,
        input  s_cmd_ready, s_data_in_tready, s_data_out_tdata, s_data_out_tvalid,
               s_data_out_tlast, m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write,
               m_cmd_write_multiple, m_cmd_stop, m_cmd_valid, m_data_in_tdata,
               m_data_in_tvalid, m_data_in_tlast, m_data_out_tready
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one i2c_master among PORTS requesters
module i2c_master_arbiter #(
    parameter int PORTS     = 2,
    parameter int CNT_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_arbiter_if.slave bus,
    output logic [PORTS-1:0]   grant,
    output logic               busy
);
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [PORTS-1:0]     grant_q, grant_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 wm_q, wm_d;
    logic                 stop_q, stop_d;

    logic                 active;
    logic                 cmd_ok;
    logic                 cmd_hs;
    logic                 rd_hs;
    logic                 wr_last_hs;
    logic                 release_now;
    logic                 found;
    logic [IW-1:0]        winner;
    int                   cand;

    assign active      = (state_q == ACTIVE);
    assign cmd_ok      = active && !stop_q && (pending_q != '1);
    assign cmd_hs      = bus.m_cmd_valid && bus.m_cmd_ready;
    assign rd_hs       = bus.m_data_out_tvalid && bus.m_data_out_tready;
    assign wr_last_hs  = bus.m_data_in_tvalid && bus.m_data_in_tready && bus.m_data_in_tlast;
    assign release_now = active && stop_q && (pending_q == '0) && !wm_q;
    assign grant       = grant_q;
    assign busy        = active;

    // First requester above the previous owner, wrapping around
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = (int'(last_q) + k) % PORTS;
            if (!found && bus.s_cmd_valid[cand]) begin
                found  = 1'b1;
                winner = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        pending_d = pending_q;
        wm_d      = wm_q;
        stop_d    = stop_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACTIVE;
                    idx_d   = winner;
                    grant_d = PORTS'(1) << winner;
                end
            end
            ACTIVE: begin
                if (cmd_hs && bus.m_cmd_read && !rd_hs) begin
                    pending_d = pending_q + 1'b1;
                end else if (rd_hs && !(cmd_hs && bus.m_cmd_read) && (pending_q != '0)) begin
                    pending_d = pending_q - 1'b1;
                end
                if (wr_last_hs) wm_d = 1'b0;
                if (cmd_hs && bus.m_cmd_write_multiple) wm_d = 1'b1;
                if (cmd_hs && bus.m_cmd_stop) stop_d = 1'b1;
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_cmd_address        = bus.s_cmd_address[int'(idx_q)*7 +: 7];
        bus.m_cmd_start          = bus.s_cmd_start[idx_q];
        bus.m_cmd_read           = bus.s_cmd_read[idx_q];
        bus.m_cmd_write          = bus.s_cmd_write[idx_q];
        bus.m_cmd_write_multiple = bus.s_cmd_write_multiple[idx_q];
        bus.m_cmd_stop           = bus.s_cmd_stop[idx_q];
        bus.m_data_in_tdata      = bus.s_data_in_tdata[int'(idx_q)*8 +: 8];
        bus.m_data_in_tlast      = bus.s_data_in_tlast[idx_q];
        bus.s_data_out_tdata     = bus.m_data_out_tdata;
        bus.m_cmd_valid          = 1'b0;
        bus.m_data_in_tvalid     = 1'b0;
        bus.m_data_out_tready    = 1'b0;
        bus.s_cmd_ready          = '0;
        bus.s_data_in_tready     = '0;
        bus.s_data_out_tvalid    = '0;
        bus.s_data_out_tlast     = '0;
        if (active) begin
            bus.m_cmd_valid               = cmd_ok && bus.s_cmd_valid[idx_q];
            bus.s_cmd_ready[idx_q]        = cmd_ok && bus.m_cmd_ready;
            bus.m_data_in_tvalid          = bus.s_data_in_tvalid[idx_q];
            bus.s_data_in_tready[idx_q]   = bus.m_data_in_tready;
            bus.m_data_out_tready         = bus.s_data_out_tready[idx_q];
            bus.s_data_out_tvalid[idx_q]  = bus.m_data_out_tvalid;
            bus.s_data_out_tlast[idx_q]   = bus.m_data_out_tlast;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= IW'(PORTS - 1);
            pending_q <= '0;
            wm_q      <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            wm_q      <= wm_d;
            stop_q    <= stop_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;
    localparam int PORTS     = 2;
    localparam int CNT_WIDTH = 6;
    localparam int MAXP      = (1 << CNT_WIDTH) - 1;
    localparam logic [4:0] F_START = 5'b10000;
    localparam logic [4:0] F_READ  = 5'b01000;
    localparam logic [4:0] F_WRITE = 5'b00100;
    localparam logic [4:0] F_WM    = 5'b00010;
    localparam logic [4:0] F_STOP  = 5'b00001;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [PORTS-1:0] grant;
    logic             busy;
    int               errors = 0;
    int               checks = 0;

    // Transaction-level model of who owns the master and what it still owes
    int               m_owner = -1;
    int               m_last  = PORTS - 1;
    int               m_pend  = 0;
    bit               m_wm    = 1'b0;
    bit               m_stop  = 1'b0;

    logic [PORTS-1:0] glog[$];
    logic [PORTS-1:0] gprev = '0;
    logic [7:0]       rx_q[$];
    int               acc0 = 0;

    i2c_master_arbiter_if #(.PORTS(PORTS)) bus();

    i2c_master_arbiter #(.PORTS(PORTS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake did not occur within bound at %0t", name, $time);
    endtask

    always @(posedge clk or negedge rst) begin : model
        int  o;
        int  c;
        bit  took;
        bit  rd_beat;
        bit  last_beat;
        bit  rel;
        if (!rst) begin
            m_owner = -1;
            m_last  = PORTS - 1;
            m_pend  = 0;
            m_wm    = 1'b0;
            m_stop  = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= PORTS; k++) begin
                c = (m_last + k) % PORTS;
                if (m_owner < 0 && bus.s_cmd_valid[c]) m_owner = c;
            end
        end else begin
            o         = m_owner;
            rel       = m_stop && (m_pend == 0) && !m_wm;
            took      = !m_stop && (m_pend < MAXP) && bus.s_cmd_valid[o] && bus.m_cmd_ready;
            rd_beat   = bus.m_data_out_tvalid && bus.s_data_out_tready[o];
            last_beat = bus.s_data_in_tvalid[o] && bus.m_data_in_tready && bus.s_data_in_tlast[o];
            if (took && bus.s_cmd_read[o]) m_pend++;
            if (rd_beat && m_pend > 0) m_pend--;
            if (last_beat) m_wm = 1'b0;
            if (took && bus.s_cmd_write_multiple[o]) m_wm = 1'b1;
            if (took && bus.s_cmd_stop[o]) m_stop = 1'b1;
            if (rel) begin
                m_last  = o;
                m_owner = -1;
                m_stop  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int               o;
        bit               act;
        bit               cok;
        logic [PORTS-1:0] e_scr;
        logic [PORTS-1:0] e_sdr;
        logic [PORTS-1:0] e_sov;
        logic [PORTS-1:0] e_sol;
        o     = m_owner;
        act   = (o >= 0);
        cok   = act && !m_stop && (m_pend < MAXP);
        e_scr = '0;
        e_sdr = '0;
        e_sov = '0;
        e_sol = '0;
        if (act) begin
            e_scr[o] = cok && bus.m_cmd_ready;
            e_sdr[o] = bus.m_data_in_tready;
            e_sov[o] = bus.m_data_out_tvalid;
            e_sol[o] = bus.m_data_out_tlast;
        end
        chk("grant", grant, act ? (32'd1 << o) : 32'd0);
        chk("busy", busy, act);
        chk("m_cmd_valid", bus.m_cmd_valid, cok && bus.s_cmd_valid[o]);
        chk("s_cmd_ready", bus.s_cmd_ready, e_scr);
        chk("m_data_in_tvalid", bus.m_data_in_tvalid, act && bus.s_data_in_tvalid[o]);
        chk("s_data_in_tready", bus.s_data_in_tready, e_sdr);
        chk("m_data_out_tready", bus.m_data_out_tready, act && bus.s_data_out_tready[o]);
        chk("s_data_out_tvalid", bus.s_data_out_tvalid, e_sov);
        chk("s_data_out_tlast", bus.s_data_out_tlast, e_sol);
        chk("s_data_out_tdata", bus.s_data_out_tdata, bus.m_data_out_tdata);
        if (act) begin
            chk("m_cmd_address", bus.m_cmd_address, bus.s_cmd_address[o*7 +: 7]);
            chk("m_cmd_flags",
                {bus.m_cmd_start, bus.m_cmd_read, bus.m_cmd_write, bus.m_cmd_write_multiple, bus.m_cmd_stop},
                {bus.s_cmd_start[o], bus.s_cmd_read[o], bus.s_cmd_write[o],
                 bus.s_cmd_write_multiple[o], bus.s_cmd_stop[o]});
            chk("m_data_in_tdata", bus.m_data_in_tdata, bus.s_data_in_tdata[o*8 +: 8]);
            chk("m_data_in_tlast", bus.m_data_in_tlast, bus.s_data_in_tlast[o]);
        end
    end

    always @(negedge clk) begin : mon
        if (grant != '0 && grant != gprev) glog.push_back(grant);
        gprev = grant;
        if (bus.s_data_out_tvalid[1] && bus.s_data_out_tready[1]) rx_q.push_back(bus.s_data_out_tdata);
        if (bus.s_cmd_valid[0] && bus.s_cmd_ready[0]) acc0++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input logic [6:0] a, input logic [4:0] f);
        bus.s_cmd_address[p*7 +: 7]  = a;
        bus.s_cmd_start[p]           = f[4];
        bus.s_cmd_read[p]            = f[3];
        bus.s_cmd_write[p]           = f[2];
        bus.s_cmd_write_multiple[p]  = f[1];
        bus.s_cmd_stop[p]            = f[0];
    endtask

    task automatic send_cmd(input int p, input logic [6:0] a, input logic [4:0] f);
        int n;
        set_cmd(p, a, f);
        bus.s_cmd_valid[p] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_cmd_ready[p] && n < 300);
        if (!bus.s_cmd_ready[p]) fail_timeout("cmd_handshake");
        tick(1);
        bus.s_cmd_valid[p] = 1'b0;
    endtask

    task automatic send_beat(input int p, input logic [7:0] d, input logic last);
        int n;
        bus.s_data_in_tdata[p*8 +: 8] = d;
        bus.s_data_in_tlast[p]        = last;
        bus.s_data_in_tvalid[p]       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_data_in_tready[p] && n < 300);
        if (!bus.s_data_in_tready[p]) fail_timeout("write_beat");
        tick(1);
        bus.s_data_in_tvalid[p] = 1'b0;
        bus.s_data_in_tlast[p]  = 1'b0;
    endtask

    task automatic master_rd(input logic [7:0] d, input logic last);
        int n;
        bus.m_data_out_tdata  = d;
        bus.m_data_out_tlast  = last;
        bus.m_data_out_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_data_out_tready && n < 300);
        if (!bus.m_data_out_tready) fail_timeout("read_beat");
        tick(1);
        bus.m_data_out_tvalid = 1'b0;
        bus.m_data_out_tlast  = 1'b0;
    endtask

    initial begin
        logic [PORTS-1:0] exp2 [4];
        logic [7:0]       exp3 [3];
        exp2 = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp3 = '{8'h11, 8'h22, 8'h33};

        bus.s_cmd_address = '0;  bus.s_cmd_start = '0; bus.s_cmd_read = '0;
        bus.s_cmd_write = '0;    bus.s_cmd_write_multiple = '0; bus.s_cmd_stop = '0;
        bus.s_cmd_valid = '0;    bus.s_data_in_tdata = '0; bus.s_data_in_tvalid = '0;
        bus.s_data_in_tlast = '0; bus.s_data_out_tready = '0;
        bus.m_cmd_ready = 1'b1;  bus.m_data_in_tready = 1'b1;
        bus.m_data_out_tdata = '0; bus.m_data_out_tvalid = 1'b0; bus.m_data_out_tlast = 1'b0;

        // Reset holds everything quiet even with a request pending
        bus.s_cmd_valid[0] = 1'b1;
        @(negedge clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_m_cmd_valid", bus.m_cmd_valid, 1'b0);
        tick(2);
        bus.s_cmd_valid[0] = 1'b0;
        rst = 1'b1;
        tick(1);

        // Single write with start+stop from port 0
        set_cmd(0, 7'h50, F_START | F_WRITE | F_STOP);
        bus.s_cmd_valid[0] = 1'b1;
        bus.s_data_in_tdata[7:0] = 8'hA5;
        bus.s_data_in_tlast[0] = 1'b1;
        bus.s_data_in_tvalid[0] = 1'b1;
        @(negedge clk);
        chk("t1_arb_cycle_grant", grant, 2'b00);
        @(negedge clk);
        chk("t1_grant", grant, 2'b01);
        chk("t1_addr", bus.m_cmd_address, 7'h50);
        chk("t1_wdata", bus.m_data_in_tdata, 8'hA5);
        tick(1);
        bus.s_cmd_valid[0] = 1'b0;
        bus.s_data_in_tvalid[0] = 1'b0;
        bus.s_data_in_tlast[0] = 1'b0;
        @(negedge clk);
        chk("t1_hold_until_release", grant, 2'b01);
        @(negedge clk);
        chk("t1_release_grant", grant, 2'b00);
        chk("t1_release_busy", busy, 1'b0);
        tick(2);

        // Round-robin between simultaneous requesters, starting fresh from reset
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        glog.delete();
        fork
            send_cmd(0, 7'h20, F_START | F_WRITE | F_STOP);
            send_cmd(1, 7'h21, F_START | F_WRITE | F_STOP);
        join
        tick(3);
        fork
            send_cmd(0, 7'h22, F_START | F_WRITE | F_STOP);
            send_cmd(1, 7'h23, F_START | F_WRITE | F_STOP);
        join
        tick(4);
        chk("t2_order_len", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) chk("t2_order", glog[i], exp2[i]);
        end

        // Three reads on port 1 with a back-pressured first byte
        rx_q.delete();
        send_cmd(1, 7'h48, F_START | F_READ);
        send_cmd(1, 7'h48, F_READ);
        send_cmd(1, 7'h48, F_READ | F_STOP);
        @(negedge clk);
        chk("t3_model_pend", m_pend, 3);
        chk("t3_grant_held", grant, 2'b10);
        tick(1);
        fork
            begin
                master_rd(8'h11, 1'b0);
                master_rd(8'h22, 1'b0);
                master_rd(8'h33, 1'b1);
            end
            begin
                bus.s_data_out_tready[1] = 1'b0;
                tick(5);
                bus.s_data_out_tready[1] = 1'b1;
            end
        join
        @(negedge clk);
        chk("t3_grant_after_last_byte", grant, 2'b10);
        @(negedge clk);
        chk("t3_release", grant, 2'b00);
        chk("t3_rx_len", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) chk("t3_rx_byte", rx_q[i], exp3[i]);
        end
        tick(2);

        // Write-multiple burst on port 0 while port 1 waits
        glog.delete();
        bus.m_data_in_tready = 1'b0;
        fork
            begin
                send_cmd(0, 7'h50, F_START | F_WRITE | F_WM | F_STOP);
                send_beat(0, 8'h01, 1'b0);
                send_beat(0, 8'h02, 1'b0);
                send_beat(0, 8'h03, 1'b0);
                send_beat(0, 8'h04, 1'b1);
                @(negedge clk);
                chk("t4_hold_after_tlast", grant, 2'b01);
                @(negedge clk);
                chk("t4_release", grant, 2'b00);
                @(negedge clk);
                chk("t4_next_grant", grant, 2'b10);
                tick(1);
            end
            send_cmd(1, 7'h51, F_START | F_WRITE | F_STOP);
            begin
                tick(4);
                bus.m_data_in_tready = 1'b1;
            end
        join
        tick(4);
        chk("t4_order_len", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t4_order0", glog[0], 2'b01);
            chk("t4_order1", glog[1], 2'b10);
        end

        // Repeated start on port 0 keeps the grant; port 1 blocked meanwhile
        glog.delete();
        bus.s_data_out_tready[0] = 1'b1;
        fork
            begin
                send_cmd(0, 7'h3C, F_START | F_WRITE);
                @(negedge clk);
                chk("t5_gap_grant", grant, 2'b01);
                chk("t5_p1_blocked", bus.s_cmd_ready[1], 1'b0);
                tick(1);
                send_cmd(0, 7'h3C, F_START | F_READ | F_STOP);
                master_rd(8'h5A, 1'b1);
            end
            send_cmd(1, 7'h3D, F_START | F_WRITE | F_STOP);
        join
        tick(4);
        chk("t5_order_len", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t5_order0", glog[0], 2'b01);
            chk("t5_order1", glog[1], 2'b10);
        end

        // Asynchronous reset in the middle of a read transaction
        send_cmd(1, 7'h29, F_START | F_READ);
        send_cmd(1, 7'h29, F_READ);
        @(negedge clk);
        chk("t6_model_pend", m_pend, 2);
        tick(1);
        bus.s_data_out_tready[1] = 1'b0;
        bus.m_data_out_tdata = 8'h77;
        bus.m_data_out_tvalid = 1'b1;
        @(negedge clk);
        chk("t6_pre_tvalid", bus.s_data_out_tvalid[1], 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_tvalid", bus.s_data_out_tvalid, 2'b00);
        chk("t6_rst_m_tready", bus.m_data_out_tready, 1'b0);
        chk("t6_rst_model_pend", m_pend, 0);
        bus.m_data_out_tvalid = 1'b0;
        tick(2);
        rst = 1'b1;
        set_cmd(1, 7'h2A, F_START | F_WRITE | F_STOP);
        bus.s_cmd_valid[1] = 1'b1;
        @(negedge clk);
        chk("t6_arb_cycle", grant, 2'b00);
        @(negedge clk);
        chk("t6_regrant", grant, 2'b10);
        tick(1);
        bus.s_cmd_valid[1] = 1'b0;
        tick(3);

        // Outstanding-read counter saturates and stalls further commands
        bus.s_data_out_tready[0] = 1'b1;
        acc0 = 0;
        set_cmd(0, 7'h10, F_START | F_READ);
        bus.s_cmd_valid[0] = 1'b1;
        tick(MAXP + 10);
        chk("t7_accepts", acc0, 63);
        chk("t7_model_sat", m_pend, 63);
        @(negedge clk);
        chk("t7_stalled", bus.m_cmd_valid, 1'b0);
        tick(1);
        bus.s_cmd_valid[0] = 1'b0;
        master_rd(8'h01, 1'b0);
        send_cmd(0, 7'h10, F_STOP);
        for (int i = 0; i < 62; i++) master_rd(8'(i), (i == 61));
        tick(3);
        chk("t7_release", grant, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
